// File: rtl/spike_pkg.sv
// Shared definitions for the spike decoder: register map, STATUS layout,
// FSM encoding and the saturating count helper.
package spike_pkg;

   localparam logic [3:0] ADDR_CTRL     = 4'd0;
   localparam logic [3:0] ADDR_WINDOW   = 4'd1;
   localparam logic [3:0] ADDR_PRESCALE = 4'd2;
   localparam logic [3:0] ADDR_STATUS   = 4'd3;
   localparam logic [3:0] ADDR_DATA     = 4'd4;
   localparam logic [3:0] ADDR_LIVE     = 4'd5;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_LVL_LSB = 3;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   localparam logic [7:0] WINDOW_RST = 8'd16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_COUNT = 2'd2,
      S_EMIT  = 2'd3
   } state_e;

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
      logic [7:0] r;
      if (inc && (v != 8'hFF)) begin
         r = v + 8'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/spike_fifo.sv
// Small synchronous FIFO for decoded window values; a push and a pop in the
// same clock both take effect, even when full.
module spike_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [7:0]               data_i,
   output logic [7:0]               head_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_q;
   logic [AW-1:0] wr_q;
   logic [AW:0]   lvl_q;
   logic          do_pop_s;
   logic          do_push_s;

   assign empty_o    = (lvl_q == {(AW + 1){1'b0}});
   assign full_o     = (lvl_q == LVL_FULL);
   assign level_o    = lvl_q;
   assign head_o     = mem_q[rd_q];
   assign do_pop_s   = pop_i & ~empty_o & ~flush_i;
   // A pop in the same clock frees the slot, so a full FIFO still accepts the push.
   assign do_push_s  = push_i & ~flush_i & (~full_o | do_pop_s);
   assign overflow_o = push_i & ~flush_i & full_o & ~do_pop_s;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
         rd_q  <= {AW{1'b0}};
         wr_q  <= {AW{1'b0}};
         lvl_q <= {(AW + 1){1'b0}};
      end else if (flush_i) begin
         rd_q  <= {AW{1'b0}};
         wr_q  <= {AW{1'b0}};
         lvl_q <= {(AW + 1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_q <= rd_q + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   lvl_q <= lvl_q + LVL_ONE;
            2'b01:   lvl_q <= lvl_q - LVL_ONE;
            default: lvl_q <= lvl_q;
         endcase
      end
   end

endmodule

// File: rtl/tqvp_spike_decoder.sv
// Spike-train receiver peripheral: counts synchronised rising edges over a
// window of prescaled ticks and queues one saturated 8-bit count per window.
module tqvp_spike_decoder
   import spike_pkg::*;
#(
   parameter int IN_BIT     = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic       sync1_q, sync2_q, prev_q, edge_pulse_q;
   logic       en_q, ovf_q;
   logic [7:0] window_q, prescale_q;
   logic [7:0] count_q, tick_cnt_q, presc_q, last_q;
   state_e     state_q;

   logic          edge_s, tick_s, win_end_s, running_s;
   logic [7:0]    win_last_s, cnt_next_s;
   logic          wr_ctrl_s, flush_s, pop_s;
   logic [7:0]    fifo_head_s;
   logic          fifo_empty_s, fifo_full_s, fifo_ovf_s;
   logic [LW-1:0] fifo_level_s;
   logic [7:0]    status_s;
   logic          unused_pins_s;

   assign unused_pins_s = ^ui_in;

   assign edge_s     = sync2_q & ~prev_q;
   assign running_s  = (state_q == S_COUNT) || (state_q == S_EMIT);
   assign tick_s     = (state_q != S_IDLE) && (presc_q >= prescale_q);
   // WINDOW=0 behaves as a one-tick window; >= lets a shrunk window end at once.
   assign win_last_s = (window_q == 8'd0) ? 8'd0 : (window_q - 8'd1);
   assign cnt_next_s = sat_inc(count_q, edge_s);
   assign win_end_s  = en_q && running_s && tick_s && (tick_cnt_q >= win_last_s);

   assign wr_ctrl_s = data_write && (address == ADDR_CTRL);
   assign flush_s   = wr_ctrl_s && data_in[CTRL_FLUSH];
   assign pop_s     = data_write && (address == ADDR_DATA);

   spike_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (win_end_s),
      .pop_i      (pop_s),
      .flush_i    (flush_s),
      .data_i     (cnt_next_s),
      .head_o     (fifo_head_s),
      .empty_o    (fifo_empty_s),
      .full_o     (fifo_full_s),
      .level_o    (fifo_level_s),
      .overflow_o (fifo_ovf_s)
   );

   // Pin synchroniser, rising-edge history and the one-clock edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         prev_q       <= 1'b0;
         edge_pulse_q <= 1'b0;
      end else begin
         sync1_q      <= ui_in[IN_BIT];
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         edge_pulse_q <= edge_s;
      end
   end

   // Window FSM with prescaler, counters and last emitted value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= 8'd0;
         tick_cnt_q <= 8'd0;
         presc_q    <= 8'd0;
         last_q     <= 8'd0;
      end else if (!en_q) begin
         state_q    <= S_IDLE;
         count_q    <= 8'd0;
         tick_cnt_q <= 8'd0;
         presc_q    <= 8'd0;
      end else begin
         presc_q <= ((state_q == S_IDLE) || tick_s) ? 8'd0 : (presc_q + 8'd1);
         case (state_q)
            S_IDLE: state_q <= S_ARM;
            S_ARM: begin
               if (tick_s) begin
                  state_q    <= S_COUNT;
                  count_q    <= 8'd0;
                  tick_cnt_q <= 8'd0;
               end
            end
            // EMIT starts with zeroed counters, so an edge or tick in it opens the new window.
            S_COUNT, S_EMIT: begin
               if (win_end_s) begin
                  state_q    <= S_EMIT;
                  last_q     <= cnt_next_s;
                  count_q    <= 8'd0;
                  tick_cnt_q <= 8'd0;
               end else begin
                  state_q <= S_COUNT;
                  count_q <= cnt_next_s;
                  if (tick_s) begin
                     tick_cnt_q <= tick_cnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Software-visible control registers and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         window_q   <= WINDOW_RST;
         prescale_q <= 8'd0;
         ovf_q      <= 1'b0;
      end else begin
         if (wr_ctrl_s) begin
            en_q <= data_in[CTRL_EN];
         end
         if (data_write && (address == ADDR_WINDOW)) begin
            window_q <= data_in;
         end
         if (data_write && (address == ADDR_PRESCALE)) begin
            prescale_q <= data_in;
         end
         if (fifo_ovf_s) begin
            ovf_q <= 1'b1;
         end else if (data_write && (address == ADDR_STATUS) && data_in[ST_OVF]) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign status_s = {2'b00, 3'(fifo_level_s), ovf_q, fifo_full_s, fifo_empty_s};
   assign uo_out   = {last_q[7:2], ~fifo_empty_s, edge_pulse_q};

   // Register read mux.
   always_comb begin
      data_out = 8'd0;
      case (address)
         ADDR_CTRL:     data_out = {7'd0, en_q};
         ADDR_WINDOW:   data_out = window_q;
         ADDR_PRESCALE: data_out = prescale_q;
         ADDR_STATUS:   data_out = status_s;
         ADDR_DATA:     data_out = fifo_empty_s ? 8'd0 : fifo_head_s;
         ADDR_LIVE:     data_out = count_q;
         default:       data_out = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_tqvp_spike_decoder.sv
// Bench for tqvp_spike_decoder: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_tqvp_spike_decoder;

   localparam int PIN = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   int n_cmp = 0;
   int n_bad = 0;

   tqvp_spike_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 disabled/idle, 1 waiting for first tick, 2 measuring windows
   bit         m_en, m_ovf, m_pulse;
   int         m_win, m_pre, m_mode, m_since, m_ticks, m_cnt;
   logic [7:0] m_last;
   bit         m_hist[3];
   logic [7:0] m_q[$];

   task automatic model_reset();
      m_en = 0; m_ovf = 0; m_pulse = 0;
      m_win = 16; m_pre = 0; m_mode = 0; m_since = 0; m_ticks = 0; m_cnt = 0;
      m_last = 8'd0;
      m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      bit e, tick, push, flush, pop;
      int c, wlen;
      logic [7:0] pv;
      // a rise becomes countable two samples after it is first seen
      e = m_hist[1] && !m_hist[0];
      m_hist[0] = m_hist[1]; m_hist[1] = m_hist[2]; m_hist[2] = ui_in[PIN];
      tick = (m_mode != 0) && (m_since >= m_pre);
      wlen = (m_win == 0) ? 1 : m_win;
      push = 0; pv = 8'd0;
      if (!m_en) begin
         m_mode = 0; m_cnt = 0; m_ticks = 0; m_since = 0;
      end else begin
         m_since = (m_mode == 0 || tick) ? 0 : m_since + 1;
         if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (tick) begin m_mode = 2; m_cnt = 0; m_ticks = 0; end
         end else begin
            c = m_cnt + (e ? 1 : 0);
            if (c > 255) c = 255;
            if (tick && (m_ticks + 1 >= wlen)) begin
               push = 1; pv = 8'(c); m_cnt = 0; m_ticks = 0;
            end else begin
               m_cnt = c;
               if (tick) m_ticks = m_ticks + 1;
            end
         end
      end
      m_pulse = e;
      if (push) m_last = pv;
      flush = 0; pop = 0;
      if (data_write) begin
         case (address)
            4'd0: begin m_en = data_in[0]; flush = data_in[1]; end
            4'd1: m_win = int'(data_in);
            4'd2: m_pre = int'(data_in);
            4'd3: if (data_in[2]) m_ovf = 0;
            4'd4: pop = 1;
            default: ;
         endcase
      end
      if (flush) begin
         m_q.delete();
      end else begin
         if (pop && m_q.size() > 0) void'(m_q.pop_front());
         if (push) begin
            if (m_q.size() < 4) m_q.push_back(pv);
            else m_ovf = 1;
         end
      end
   endtask

   function automatic logic [7:0] exp_uo();
      return {m_last[7:2], (m_q.size() != 0), m_pulse};
   endfunction

   function automatic logic [7:0] exp_data(input logic [3:0] a);
      logic [7:0] r;
      case (a)
         4'd0: r = {7'd0, m_en};
         4'd1: r = 8'(m_win);
         4'd2: r = 8'(m_pre);
         4'd3: r = {2'b00, 3'(m_q.size()), m_ovf, (m_q.size() == 4), (m_q.size() == 0)};
         4'd4: r = (m_q.size() != 0) ? m_q[0] : 8'd0;
         4'd5: r = 8'(m_cnt);
         default: r = 8'd0;
      endcase
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check8("uo_out", uo_out, exp_uo());
      check8("data_out", data_out, exp_data(address));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address = a; data_in = d; data_write = 1'b1;
      cyc();
      data_write = 1'b0;
   endtask

   task automatic rd_check(input string nm, input logic [3:0] a, input logic [7:0] exp);
      address = a; #1;
      check8(nm, data_out, exp);
   endtask

   task automatic wait_nonempty(input string nm, input int max);
      for (int i = 0; i < max && !uo_out[1]; i++) cyc();
      check8(nm, {7'd0, uo_out[1]}, 8'h01);
   endtask

   initial begin
      rst_n = 1'b0; ui_in = 8'd0; address = 4'd0; data_write = 1'b0; data_in = 8'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc();

      // reset values
      check8("rst_uo", uo_out, 8'h00);
      rd_check("rst_ctrl", 4'd0, 8'h00);
      rd_check("rst_window", 4'd1, 8'h10);
      rd_check("rst_prescale", 4'd2, 8'h00);
      rd_check("rst_status", 4'd3, 8'h01);
      rd_check("rst_data", 4'd4, 8'h00);

      // 1: three edges in a 10-tick window
      wr(4'd1, 8'd10);
      wr(4'd0, 8'h01);
      for (int k = 0; k < 3; k++) begin
         ui_in[PIN] = 1'b1; cyc(); ui_in[PIN] = 1'b0; cyc();
      end
      wait_nonempty("t1_wait", 40);
      rd_check("t1_data", 4'd4, 8'd3);
      rd_check("t1_status", 4'd3, 8'h08);
      wr(4'd4, 8'h00);
      rd_check("t1_empty_after_pop", 4'd3, 8'h01);
      wr(4'd0, 8'h00);

      // 2: idle windows fill the FIFO and overflow
      wr(4'd0, 8'h02);
      wr(4'd1, 8'd2);
      wr(4'd0, 8'h01);
      repeat (16) cyc();
      rd_check("t2_status_full", 4'd3, 8'h26);
      rd_check("t2_data", 4'd4, 8'h00);
      wr(4'd0, 8'h00);
      wr(4'd3, 8'h04);
      rd_check("t2_ovf_cleared", 4'd3, 8'h22);
      wr(4'd0, 8'h02);

      // 3: saturation at 255
      wr(4'd2, 8'd3);
      wr(4'd1, 8'd200);
      wr(4'd0, 8'h01);
      for (int i = 0; i < 1200; i++) begin
         ui_in[PIN] = ~ui_in[PIN];
         cyc();
         if (uo_out[1]) break;
      end
      check8("t3_wait", {7'd0, uo_out[1]}, 8'h01);
      rd_check("t3_data", 4'd4, 8'hFF);
      check8("t3_uo_hi", {2'b00, uo_out[7:2]}, 8'h3F);
      ui_in[PIN] = 1'b0;
      wr(4'd0, 8'h00);
      wr(4'd0, 8'h02);
      wr(4'd2, 8'd0);

      // 4: edge counted during EMIT belongs to the next window
      wr(4'd1, 8'd4);
      wr(4'd0, 8'h01);
      repeat (4) cyc();
      ui_in[PIN] = 1'b1; cyc();
      ui_in[PIN] = 1'b0; cyc();
      check8("t4_nonempty", {7'd0, uo_out[1]}, 8'h01);
      rd_check("t4_data", 4'd4, 8'h00);
      rd_check("t4_live_emit", 4'd5, 8'h00);
      cyc();
      rd_check("t4_live_next", 4'd5, 8'h01);
      wr(4'd0, 8'h00);
      wr(4'd0, 8'h02);

      // 5: disable mid-window discards the partial count
      wr(4'd1, 8'd10);
      wr(4'd0, 8'h01);
      for (int k = 0; k < 2; k++) begin
         ui_in[PIN] = 1'b1; cyc(); ui_in[PIN] = 1'b0; cyc();
      end
      repeat (2) cyc();
      wr(4'd0, 8'h00);
      repeat (15) cyc();
      rd_check("t5_status", 4'd3, 8'h01);
      rd_check("t5_live", 4'd5, 8'h00);
      wr(4'd0, 8'h01);
      ui_in[PIN] = 1'b1; cyc(); ui_in[PIN] = 1'b0;
      wait_nonempty("t5_wait", 40);
      rd_check("t5_data", 4'd4, 8'd1);
      wr(4'd0, 8'h00);
      wr(4'd0, 8'h02);

      // 6: asynchronous reset with entries queued
      wr(4'd1, 8'd2);
      wr(4'd0, 8'h01);
      address = 4'd3;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (data_out[5:3] == 3'd2) break;
         cyc();
      end
      check8("t6_level2", {5'd0, data_out[5:3]}, 8'h02);
      rst_n = 1'b0;
      model_reset();
      #1;
      rd_check("t6_status", 4'd3, 8'h01);
      check8("t6_uo", uo_out, 8'h00);
      rd_check("t6_window", 4'd1, 8'h10);
      rd_check("t6_ctrl", 4'd0, 8'h00);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [7:0] r;
         r = 8'($urandom);
         r[PIN] = ($urandom_range(0, 2) == 0) ? ~ui_in[PIN] : ui_in[PIN];
         ui_in = r;
         address = 4'($urandom_range(0, 15));
         data_write = ($urandom_range(0, 5) == 0);
         data_in = 8'($urandom);
         case (address)
            4'd0: begin
               data_in[0] = ($urandom_range(0, 9) != 0);
               data_in[1] = ($urandom_range(0, 7) == 0);
            end
            4'd1: data_in = 8'($urandom_range(0, 6));
            4'd2: data_in = 8'($urandom_range(0, 2));
            default: ;
         endcase
         cyc();
      end
      data_write = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
